alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one external combinational ALU between two requesters.
//   A request is granted in IDLE (round-robin on a tie), its operands are
//   registered and presented to the ALU for one EXEC cycle, the ALU outputs
//   are captured, and the response is held in RESP until the granted
//   requester accepts it.
//
// Handshake rule (both request and response channels): a transfer happens on
// a rising clk edge where valid and ready of the same bit are both 1. Valid
// and ready are independent of each other's value on the same bit.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req_valid[1:0]           request strobe per requester
//   o_req_ready[1:0]           request accept per requester (IDLE winner only)
//   i_req{0,1}_a/_b[W-1:0]     operands per requester
//   i_req{0,1}_op[1:0]         opcode per requester (not decoded here)
//   o_rsp_valid[1:0]           response strobe, only the granted bit
//   i_rsp_ready[1:0]           response accept; non-granted bit ignored
//   o_rsp_result[W-1:0]        captured ALU result
//   o_rsp_overflow, o_rsp_zero captured ALU flags
//   o_alu_a/_b[W-1:0], o_alu_op[1:0]  registered operands to the ALU
//   i_alu_result[W-1:0], i_alu_overflow, i_alu_zero  ALU outputs
//   o_busy                     high whenever not IDLE
//   o_op_count[7:0]            completed operations, wraps at 255
//   o_state[1:0]               FSM state for debug (0 IDLE, 1 EXEC, 2 RESP)
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   i_req_valid,
  output logic [1:0]   o_req_ready,
  input  logic [W-1:0] i_req0_a,
  input  logic [W-1:0] i_req0_b,
  input  logic [1:0]   i_req0_op,
  input  logic [W-1:0] i_req1_a,
  input  logic [W-1:0] i_req1_b,
  input  logic [1:0]   i_req1_op,
  output logic [1:0]   o_rsp_valid,
  input  logic [1:0]   i_rsp_ready,
  output logic [W-1:0] o_rsp_result,
  output logic         o_rsp_overflow,
  output logic         o_rsp_zero,
  output logic [W-1:0] o_alu_a,
  output logic [W-1:0] o_alu_b,
  output logic [1:0]   o_alu_op,
  input  logic [W-1:0] i_alu_result,
  input  logic         i_alu_overflow,
  input  logic         i_alu_zero,
  output logic         o_busy,
  output logic [7:0]   o_op_count,
  output logic [1:0]   o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;

  logic         r_last_grant;
  logic         r_gid;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [1:0]   r_op;
  logic [W-1:0] r_res;
  logic         r_ovf;
  logic         r_zero;
  logic [7:0]   r_count;

  logic         w_grant_id;
  logic         w_accept;
  logic         w_rsp_done;

  // Winner among current requests; on a tie the one not served last wins.
  always_comb begin
    w_grant_id = 1'b0;
    case (i_req_valid)
      2'b01:   w_grant_id = 1'b0;
      2'b10:   w_grant_id = 1'b1;
      2'b11:   w_grant_id = ~r_last_grant;
      default: w_grant_id = 1'b0;
    endcase
  end

  // The winner's ready is always 1 in IDLE, so any valid request is accepted.
  assign w_accept   = (r_state == S_IDLE) && (|i_req_valid);
  assign w_rsp_done = (r_state == S_RESP) && i_rsp_ready[r_gid];

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (w_rsp_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // o_req_ready is gated by rst_n so it drops immediately while reset is
  // held even if requests are pending in IDLE.
  always_comb begin
    o_req_ready = 2'b00;
    o_rsp_valid = 2'b00;
    o_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rst_n && (|i_req_valid)) o_req_ready[w_grant_id] = 1'b1;
      end
      S_EXEC: begin
        o_busy = 1'b1;
      end
      S_RESP: begin
        o_busy             = 1'b1;
        o_rsp_valid[r_gid] = 1'b1;
      end
      default: begin
        o_busy = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_gid        <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 2'b00;
      r_res        <= '0;
      r_ovf        <= 1'b0;
      r_zero       <= 1'b0;
      r_count      <= 8'd0;
    end else begin
      if (w_accept) begin
        r_gid <= w_grant_id;
        r_a   <= w_grant_id ? i_req1_a  : i_req0_a;
        r_b   <= w_grant_id ? i_req1_b  : i_req0_b;
        r_op  <= w_grant_id ? i_req1_op : i_req0_op;
      end
      if (r_state == S_EXEC) begin
        r_res  <= i_alu_result;
        r_ovf  <= i_alu_overflow;
        r_zero <= i_alu_zero;
      end
      if (w_rsp_done) begin
        r_last_grant <= r_gid;
        r_count      <= r_count + 8'd1;
      end
    end
  end

  assign o_alu_a        = r_a;
  assign o_alu_b        = r_b;
  assign o_alu_op       = r_op;
  assign o_rsp_result   = r_res;
  assign o_rsp_overflow = r_ovf;
  assign o_rsp_zero     = r_zero;
  assign o_op_count     = r_count;
  assign o_state        = r_state;

endmodule
